wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_arbiter_rr_arbiter2.sv | 54 +++++
 rtl/wb_arbiter.sv | 92 +++++++++
 tb/tb_wb_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths,
// one-hot grant encodings and the round-robin pointer type.
package wb_arbiter_pkg;

  localparam int unsigned XLEN_DEFAULT   = 32;
  localparam int unsigned ADDR_W_DEFAULT = 5;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_S0   = 2'b01;
  localparam logic [1:0] GRANT_S1   = 2'b10;

  // Which requester wins the next simultaneous request.
  typedef enum logic {
    PrioS0 = 1'b0,
    PrioS1 = 1'b1
  } prio_e;

endpackage

// File: rtl/wb_arbiter_rr_arbiter2.sv
// Two-way grant logic. With WB_ARBITER_RR_EN defined, simultaneous requests
// alternate via a 1-bit last-grant pointer; otherwise requester 0 always wins.
module rr_arbiter2
  import wb_arbiter_pkg::*;
(
`ifdef WB_ARBITER_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       xfer_i,
`endif
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

`ifdef WB_ARBITER_RR_EN
  prio_e prio_q, prio_d;

  always_comb begin
    gnt_o = GRANT_NONE;
    case (req_i)
      2'b01:   gnt_o = GRANT_S0;
      2'b10:   gnt_o = GRANT_S1;
      2'b11:   gnt_o = (prio_q == PrioS0) ? GRANT_S0 : GRANT_S1;
      default: gnt_o = GRANT_NONE;
    endcase
  end

  // The requester just served drops to the back of the line.
  always_comb begin
    prio_d = prio_q;
    if (xfer_i) begin
      prio_d = (gnt_o == GRANT_S0) ? PrioS1 : PrioS0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= PrioS0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  always_comb begin
    gnt_o = GRANT_NONE;
    if (req_i[0]) begin
      gnt_o = GRANT_S0;
    end else if (req_i[1]) begin
      gnt_o = GRANT_S1;
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates ALU and load/store writebacks onto a single register-file write
// port, one registered write per cycle. Optional macro: WB_ARBITER_RR_EN.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid_i,
  output logic              s0_ready_o,
  input  logic [ADDR_W-1:0] s0_addr_i,
  input  logic [XLEN-1:0]   s0_data_i,
  input  logic              s1_valid_i,
  output logic              s1_ready_o,
  input  logic [ADDR_W-1:0] s1_addr_i,
  input  logic [XLEN-1:0]   s1_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic [1:0]        grant_o
);

  logic [1:0]        gnt;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]   sel_data;

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic [1:0]        grant_q, grant_d;

  rr_arbiter2 u_arb (
`ifdef WB_ARBITER_RR_EN
    .clk    (clk),
    .rst_n  (rst_n),
    .xfer_i (xfer),
`endif
    .req_i  ({s1_valid_i, s0_valid_i}),
    .gnt_o  (gnt)
  );

  // Grants only go to valid requesters, so gating with reset is all that remains.
  assign s0_ready_o = rst_n & gnt[0];
  assign s1_ready_o = rst_n & gnt[1];
  assign xfer       = s0_ready_o | s1_ready_o;

  always_comb begin
    sel_addr = s0_addr_i;
    sel_data = s0_data_i;
    if (s1_ready_o) begin
      sel_addr = s1_addr_i;
      sel_data = s1_data_i;
    end
  end

  // Writes to x0 complete the handshake but never reach the register file.
  always_comb begin
    wr_en_d   = 1'b0;
    grant_d   = GRANT_NONE;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (xfer) begin
      wr_en_d   = (sel_addr != '0);
      grant_d   = {s1_ready_o, s0_ready_o};
      rd_addr_d = sel_addr;
      rd_data_d = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      grant_q   <= GRANT_NONE;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      grant_q   <= grant_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a behavioural register file on the write
// port; expected grant sequences depend on WB_ARBITER_RR_EN.
module tb_wb_arbiter;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s0_valid_i, s1_valid_i;
  logic              s0_ready_o, s1_ready_o;
  logic [ADDR_W-1:0] s0_addr_i, s1_addr_i;
  logic [XLEN-1:0]   s0_data_i, s1_data_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [XLEN-1:0]   rd_data_o;
  logic [1:0]        grant_o;

  logic [XLEN-1:0]   rf [32];

  int n_pass = 0;
  int n_total = 0;

  wb_arbiter #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s0_valid_i (s0_valid_i),
    .s0_ready_o (s0_ready_o),
    .s0_addr_i  (s0_addr_i),
    .s0_data_i  (s0_data_i),
    .s1_valid_i (s1_valid_i),
    .s1_ready_o (s1_ready_o),
    .s1_addr_i  (s1_addr_i),
    .s1_data_i  (s1_data_i),
    .wr_en_o    (wr_en_o),
    .rd_addr_o  (rd_addr_o),
    .rd_data_o  (rd_data_o),
    .grant_o    (grant_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en_o) rf[rd_addr_o] <= rd_data_o;
  end

  function automatic logic [XLEN-1:0] rf_read(input logic [ADDR_W-1:0] a);
    return (a == '0) ? '0 : rf[a];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_g;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst_n = 1'b0;
    s0_valid_i = 1'b1; s0_addr_i = 5'd9; s0_data_i = 32'h1111_1111;
    s1_valid_i = 1'b1; s1_addr_i = 5'd9; s1_data_i = 32'h2222_2222;
    #1;
    chk("rst_ready", {s1_ready_o, s0_ready_o}, 2'b00);
    tick();
    tick();
    chk("rst_ready2", {s1_ready_o, s0_ready_o}, 2'b00);
    chk("rst_outs", {wr_en_o, grant_o, rd_addr_o, rd_data_o}, '0);

    // Single s0 write
    s1_valid_i = 1'b0;
    s0_addr_i = 5'd1; s0_data_i = 32'h1234_5678;
    rst_n = 1'b1;
    #1;
    chk("s0_ready", {s1_ready_o, s0_ready_o}, 2'b01);
    tick();
    s0_valid_i = 1'b0;
    chk("s0_wr_en", wr_en_o, 1'b1);
    chk("s0_addr", rd_addr_o, 5'd1);
    chk("s0_data", rd_data_o, 32'h1234_5678);
    chk("s0_grant", grant_o, 2'b01);
    tick();
    chk("idle_wr_en", wr_en_o, 1'b0);
    chk("idle_grant", grant_o, 2'b00);
    chk("idle_hold", {rd_addr_o, rd_data_o}, {5'd1, 32'h1234_5678});
    chk("rf_x1", rf_read(5'd1), 32'h1234_5678);

    // s1 write to x0
    s1_valid_i = 1'b1; s1_addr_i = 5'd0; s1_data_i = 32'hDEAD_BEEF;
    #1;
    chk("x0_ready", {s1_ready_o, s0_ready_o}, 2'b10);
    tick();
    s1_valid_i = 1'b0;
    chk("x0_wr_en", wr_en_o, 1'b0);
    chk("x0_grant", grant_o, 2'b10);
    tick();
    chk("x0_read", rf_read(5'd0), 32'h0);

    // Both valid for four cycles
    s0_valid_i = 1'b1; s0_addr_i = 5'd2; s0_data_i = 32'hA0A0_0002;
    s1_valid_i = 1'b1; s1_addr_i = 5'd3; s1_data_i = 32'hB0B0_0003;
    for (int i = 0; i < 4; i++) begin
`ifdef WB_ARBITER_RR_EN
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      #1;
      chk($sformatf("both_ready%0d", i), {s1_ready_o, s0_ready_o}, exp_g);
      tick();
      chk($sformatf("both_grant%0d", i), grant_o, exp_g);
      chk($sformatf("both_wr_en%0d", i), wr_en_o, 1'b1);
    end
`ifdef WB_ARBITER_RR_EN
    s0_valid_i = 1'b0; s1_valid_i = 1'b0;
    tick();
    chk("rf_x3", rf_read(5'd3), 32'hB0B0_0003);
`else
    s0_valid_i = 1'b0;
    #1;
    chk("starve_release", {s1_ready_o, s0_ready_o}, 2'b10);
    tick();
    s1_valid_i = 1'b0;
    chk("starve_grant", grant_o, 2'b10);
    chk("starve_addr", rd_addr_o, 5'd3);
    tick();
`endif
    chk("rf_x2", rf_read(5'd2), 32'hA0A0_0002);

    // Reset on the edge after an accept
    s0_valid_i = 1'b1; s0_addr_i = 5'd7; s0_data_i = 32'h7777_7777;
    #1;
    chk("pre_rst_ready", s0_ready_o, 1'b1);
    tick();
    rst_n = 1'b0;
    s0_data_i = 32'h8888_8888;
    s1_valid_i = 1'b1; s1_addr_i = 5'd7; s1_data_i = 32'h9999_9999;
    #1;
    chk("in_rst_ready", {s1_ready_o, s0_ready_o}, 2'b00);
    tick();
    chk("post_rst_outs", {wr_en_o, grant_o, rd_addr_o, rd_data_o}, '0);
    chk("post_rst_ready", {s1_ready_o, s0_ready_o}, 2'b00);
    tick();
    chk("post_rst_ready2", {s1_ready_o, s0_ready_o}, 2'b00);

    // Same-address collision straight out of reset: s0 wins first
    s0_addr_i = 5'd5; s0_data_i = 32'hAAAA_AAAA;
    s1_addr_i = 5'd5; s1_data_i = 32'h5555_5555;
    rst_n = 1'b1;
    #1;
    chk("col_ready0", {s1_ready_o, s0_ready_o}, 2'b01);
    tick();
    s0_valid_i = 1'b0;
    chk("col_grant0", grant_o, 2'b01);
    #1;
    chk("col_ready1", {s1_ready_o, s0_ready_o}, 2'b10);
    tick();
    s1_valid_i = 1'b0;
    chk("col_grant1", grant_o, 2'b10);
    tick();
    chk("col_x5", rf_read(5'd5), 32'h5555_5555);
    chk("col_idle", {wr_en_o, grant_o}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
